sr_muldiv: RTL and testbench
============================

SR_MULDIV -- requirements
Module: sr_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 needs to be supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request pulse from CPU control; sampled on rising clk.
REQ-005 SHALL have port op  input  2  operation: 00 MUL (low 32), 01 MULHU (high 32, unsigned), 10 DIVU, 11 REMU.
REQ-006 SHALL have port srcA  input  32  operand A (multiplicand / dividend).
REQ-007 SHALL have port srcB  input  32  operand B (multiplier / divisor).
REQ-008 SHALL have port busy  output  1  unit computing; CPU stalls PC while high.
REQ-009 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port result  output  32  last completed result, held until next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; busy = (state==RUN); done = (state==DONE).
REQ-012 SHALL accept start only in IDLE or DONE; on acceptance latch op, srcA, srcB, clear 5-bit iteration counter, enter RUN.
REQ-013 SHALL ignore start while in RUN; latched operands and op are not disturbed.
REQ-014 SHALL stay in RUN for exactly 32 cycles, one iteration per cycle, counter 0..31, then enter DONE.
REQ-015 SHALL go from DONE to IDLE after one cycle unless start is high, which is accepted (back-to-back).
REQ-016 SHALL give fixed latency: start sampled at edge k -> busy high at cycles k+1..k+32, done=1 and result valid at cycle k+33, busy=0 there.
REQ-017 SHALL use shift-add multiply: 64-bit product register; each iteration adds the multiplicand when the current multiplier LSB is 1, then shifts right.
REQ-018 SHALL make MUL return product[31:0] and MULHU product[63:32], both unsigned, wrap-free 64-bit.
REQ-019 SHALL use restoring division: each iteration shifts remainder left taking the next dividend MSB, subtracts the divisor when remainder >= divisor, and sets the quotient bit.
REQ-020 SHALL make DIVU return the quotient and REMU the remainder, both unsigned.
REQ-021 SHALL handle divide by zero (srcB=0): DIVU result 32'hFFFFFFFF, REMU result = srcA; still 32 busy cycles, no special timing.
REQ-022 SHALL update result register only on the RUN->DONE transition; result is stable in IDLE, DONE and during the next RUN.
REQ-023 SHALL never assert busy and done in the same cycle; done is exactly one cycle wide per accepted start.
REQ-024 SHALL have no combinational path from start/srcA/srcB/op to busy, done or result.

Reset
REQ-025 SHALL, when rst_n=0 at a rising edge, force state IDLE, counter 0, busy=0, done=0, result=0, regardless of state.
REQ-026 SHALL abort an operation in RUN when reset occurs: no done pulse, result=0; start sampled on the same edge as rst_n=0 is ignored.
REQ-027 SHALL accept start on the first edge with rst_n=1.

Verification
REQ-028 SHALL pass MUL: srcA=7, srcB=6, op=00, 1-cycle start -> busy 32 cycles, done at k+33, result=42.
REQ-029 SHALL pass MULHU: srcA=srcB=32'hFFFFFFFF, op=01 -> result=32'hFFFFFFFE; with op=00 -> result=32'h00000001.
REQ-030 SHALL pass DIVU/REMU: srcA=100, srcB=7 -> DIVU 14, REMU 2; srcB=0, srcA=123 -> DIVU 32'hFFFFFFFF, REMU 123.
REQ-031 SHALL pass start-while-busy: start MUL 3*5, re-pulse start with srcA=9 at cycle k+10 -> single done at k+33, result=15.
REQ-032 SHALL pass back-to-back: start held during DONE of DIVU 10/3 -> result 3 at done, new RUN begins next cycle, second done 33 cycles later.
REQ-033 SHALL pass reset mid-run: rst_n=0 at cycle k+16 -> busy=0, done never pulses, result=0; a fresh start afterward completes normally.

Source files
------------

// File: rtl/sr_muldiv.sv
// sr_muldiv: iterative 32-cycle unsigned multiply / divide unit.
//   Shift-add multiply (MUL low word, MULHU high word) and restoring
//   divide (DIVU quotient, REMU remainder) share one 64-bit accumulator.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           request pulse, accepted in IDLE or DONE
//   op[1:0]         00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   srcA, srcB      operands (multiplicand/dividend, multiplier/divisor)
//   busy            high for the 32 iteration cycles
//   done            one-cycle pulse when result is updated
//   result          last completed result, held until the next completion
module sr_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [1:0]         opR;
    logic [CW-1:0]      cnt;
    // Multiplicand for MUL/MULHU, divisor for DIVU/REMU.
    logic [WIDTH-1:0]   opnd;
    // Multiply: {partial product high, multiplier being shifted out}.
    // Divide:   {remainder, dividend bits shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   resNext;

    always_comb begin
        accNext = acc;
        sum     = '0;
        trial   = '0;
        diff    = '0;
        if (!opR[1]) begin
            // Carry out of the add lands in bit 63 after the right shift.
            sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
            accNext = {sum, acc[WIDTH-1:1]};
        end else begin
            // Remainder is always below the divisor, so the difference fits
            // in WIDTH bits. A zero divisor naturally yields all-ones
            // quotient and remainder equal to the dividend.
            trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            diff  = trial - {1'b0, opnd};
            if (trial >= {1'b0, opnd})
                accNext = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                accNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

    // MUL/DIVU take the low half, MULHU/REMU the high half.
    assign resNext = opR[0] ? accNext[2*WIDTH-1:WIDTH] : accNext[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            opR    <= '0;
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opR   <= op;
                        opnd  <= op[1] ? srcB : srcA;
                        acc   <= {{WIDTH{1'b0}}, (op[1] ? srcA : srcB)};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= accNext;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        result <= resNext;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_muldiv.sv
// Bench for sr_muldiv: vector table plus hand-written timing sequences,
// results checked through an expected-value queue popped on each done.
module tb_sr_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    logic [31:0] q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    sr_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return (b == 0) ? 32'hFFFFFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Scoreboard: every done pops the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (busy === 1'b1 && done === 1'b1) check("busyAndDone", {busy, done}, 2'b10);
        if (done === 1'b1) begin
            check("doneExpected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("result", result, q.pop_front());
        end
    end

    // Drives start for one edge (from the current point, before the next
    // rising edge) and waits for done, checking latency and busy width.
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int n = 0;
        int nb = 0;
        start = 1'b1; op = o; srcA = a; srcB = b;
        q.push_back(exp);
        while (1) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (busy) nb++;
            if (done || n > 40) break;
        end
        check("latency", n, 33);
        check("busyCycles", nb, 32);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;
        vecs[0] = '{2'd0, 32'd7, 32'd6, 32'd42};
        vecs[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[2] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[3] = '{2'd2, 32'd100, 32'd7, 32'd14};
        vecs[4] = '{2'd3, 32'd100, 32'd7, 32'd2};
        vecs[5] = '{2'd2, 32'd123, 32'd0, 32'hFFFFFFFF};
        vecs[6] = '{2'd3, 32'd123, 32'd0, 32'd123};
        vecs[7] = '{2'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF};
        vecs[8] = '{2'd3, 32'd5, 32'd9, 32'd5};
        vecs[9] = '{2'd1, 32'h80000000, 32'd4, 32'd2};
        for (int i = 10; i < 18; i++) begin
            vecs[i].op = 2'($urandom_range(0, 3));
            vecs[i].a  = $urandom;
            vecs[i].b  = (i == 12) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 1000)));
            vecs[i].exp = model(vecs[i].op, vecs[i].a, vecs[i].b);
        end

        // Reset state; start asserted together with reset is ignored.
        start = 1'b1; op = 2'd0; srcA = 32'd1; srcB = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("rstBusy", busy, 0);
        check("rstDone", done, 0);
        check("rstResult", result, 0);

        // Start on the very first edge with reset released.
        @(negedge clk);
        rst_n = 1'b1;
        runOp(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].exp);
        @(posedge clk); #1;
        check("doneWidth", done, 0);
        check("heldResult", result, vecs[0].exp);

        for (int i = 1; i < 18; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            @(posedge clk); #1;
            check("heldIdle", result, vecs[i].exp);
        end

        // Start re-pulsed mid-run must not disturb the operation.
        start = 1'b1; op = 2'd0; srcA = 32'd3; srcB = 32'd5;
        q.push_back(32'd15);
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (n == 9) begin start = 1'b1; srcA = 32'd9; end
            if (n == 1 || n == 20) check("busyMidRun", busy, 1);
            if (done || n > 50) break;
        end
        check("repulseLatency", n, 33);
        repeat (2) @(posedge clk);
        #1;
        check("repulseHeld", result, 32'd15);

        // Back-to-back: start held during DONE of DIVU 10/3.
        runOp(2'd2, 32'd10, 32'd3, 32'd3);
        start = 1'b1; op = 2'd0; srcA = 32'd4; srcB = 32'd5;
        q.push_back(32'd20);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2bBusy", busy, 1);
        check("b2bResultStable", result, 32'd3);
        n = 1;
        while (!done && n <= 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2bLatency", n, 33);

        // Reset mid-run aborts without a done pulse.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd0; srcA = 32'd7; srcB = 32'd6;
        n = 0;
        while (n < 15) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abortBusy", busy, 0);
        check("abortDone", done, 0);
        check("abortResult", result, 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abortNoDone", seen, 0);
        runOp(2'd0, 32'd9, 32'd9, 32'd81);
        @(posedge clk); #1;
        check("queueDrained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
